// File: rtl/arbitrary_pattern_capture.sv
// arbitrary_pattern_capture
//   Records NUM_SIG-wide samples of input_signals into an on-chip buffer once a
//   masked trigger pattern is seen, for later readback.
//
//   Optional feature macro: CAPTURE_TIMESTAMP_EN
//     defined   : free-running 32-bit wave_clk counter. Its value is latched into
//                 trig_timestamp on the trigger-match cycle.
//     undefined : no counter, and trig_timestamp reads 0.
//
// Ports
//   wave_clk, wave_reset     clock and synchronous active-high reset
//   input_signals            sampled bus, registered once before any use
//   arm / abort              1-cycle control pulses (abort wins)
//   trig_mask / trig_value   trigger pattern, latched on arm
//   capture_len              samples to record, latched on arm (0 or >NUM_SAMP -> NUM_SAMP)
//   rd_en / rd_addr          readback request; data one cycle later
//   rd_data / rd_valid       readback result
//   state                    0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE
//   samples_captured         samples written in current/last acquisition
//   trig_timestamp           counter value at trigger (0 without the macro)
module arbitrary_pattern_capture #(
  parameter int NUM_SIG  = 14,
  parameter int NUM_SAMP = 128,
  localparam int AW      = $clog2(NUM_SAMP)
) (
  input  logic               wave_clk,
  input  logic               wave_reset,
  input  logic [NUM_SIG-1:0] input_signals,
  input  logic               arm,
  input  logic               abort,
  input  logic [NUM_SIG-1:0] trig_mask,
  input  logic [NUM_SIG-1:0] trig_value,
  input  logic [AW:0]        capture_len,
  input  logic               rd_en,
  input  logic [AW:0]        rd_addr,
  output logic [NUM_SIG-1:0] rd_data,
  output logic               rd_valid,
  output logic [1:0]         state,
  output logic [AW:0]        samples_captured,
  output logic [31:0]        trig_timestamp
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic [AW:0] FULL_LEN = (AW+1)'(NUM_SAMP);

  // A request of 0, or one larger than the buffer, means "fill the whole buffer".
  function automatic logic [AW:0] clamp_len(input logic [AW:0] req);
    if (req == '0 || req > FULL_LEN) return FULL_LEN;
    return req;
  endfunction

  state_e             state_q, state_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [AW:0]        len_q, len_d;
  logic [NUM_SIG-1:0] mask_q, mask_d;
  logic [NUM_SIG-1:0] value_q, value_d;
  logic [NUM_SIG-1:0] sig_q;
  logic               match;
  logic               trig_hit;
  logic               cap_wr;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [NUM_SIG-1:0] rd_data_q;
  logic               rd_valid_q;
  logic [NUM_SIG-1:0] mem [NUM_SAMP];

  // Input register stage: every compare and write sees sig_q.
  always_ff @(posedge wave_clk) begin
    if (wave_reset) sig_q <= '0;
    else            sig_q <= input_signals;
  end

  assign match = ((sig_q ^ value_q) & mask_q) == '0;

  always_ff @(posedge wave_clk) begin
    if (wave_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= FULL_LEN;
      mask_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    mask_d   = mask_q;
    value_d  = value_q;
    trig_hit = 1'b0;
    cap_wr   = 1'b0;
    waddr    = '0;
    if (abort) begin
      // Abort beats everything, including a simultaneous trigger or arm.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = WAIT_TRIG;
            len_d   = clamp_len(capture_len);
            mask_d  = trig_mask;
            value_d = trig_value;
            cnt_d   = '0;
          end
        end
        WAIT_TRIG: begin
          if (match) begin
            trig_hit = 1'b1;
            cnt_d    = (AW+1)'(1);
            state_d  = (len_q == (AW+1)'(1)) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          cap_wr = 1'b1;
          waddr  = cnt_q[AW-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign we = trig_hit | cap_wr;

  // Simple dual-port buffer: contents survive reset.
  always_ff @(posedge wave_clk) begin
    if (we) mem[waddr] <= sig_q;
  end

  // Read port registered; a same-address write in the same cycle returns old data.
  always_ff @(posedge wave_clk) begin
    if (wave_reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= (rd_addr >= FULL_LEN) ? '0 : mem[rd_addr[AW-1:0]];
    end
  end

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] trig_ts_q;

  always_ff @(posedge wave_clk) begin
    if (wave_reset) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (trig_hit) trig_ts_q <= ts_cnt_q;
    end
  end

  assign trig_timestamp = trig_ts_q;
`else
  assign trig_timestamp = '0;
`endif

  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign state            = state_q;
  assign samples_captured = cnt_q;

endmodule
